// File: rtl/flags_unit.sv
// Processor flags register {ie, n, z, c, v} with an ALU-driven update, explicit load, and a LIFO shadow stack for interrupts.
// Latency: inputs of cycle N are visible on flags/depth/stack_err in cycle N+1. All outputs are registered.
// Backpressure: none. Illegal stack operations are dropped and flagged with a one-cycle stack_err pulse.
// Ports:
//   clock, reset            : rising-edge clock and synchronous active-high reset
//   alu_valid, result       : ALU result qualifier and {carry_out, data}
//   a_msb, b_msb, is_sub    : operand sign bits and subtract select, used for overflow
//   load_en, load_value     : explicit write of the whole flags word
//   push, pop               : save/restore flags on interrupt entry/exit
//   flags, depth, stack_err : flags word, shadow stack occupancy, and illegal stack op pulse
module flags_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int DW = PW + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           alu_valid,
  input  logic [WIDTH:0] result,
  input  logic           a_msb,
  input  logic           b_msb,
  input  logic           is_sub,
  input  logic           load_en,
  input  logic [4:0]     load_value,
  input  logic           push,
  input  logic           pop,
  output logic [4:0]     flags,
  output logic [DW-1:0]  depth,
  output logic           stack_err
);

  logic [4:0]    stack [DEPTH];
  logic [3:0]    arith;
  logic [4:0]    next_flags;
  logic [DW-1:0] depth_m1;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic          err;
  logic          ovf;
  logic          same_sign;

  // The subtract overflow test uses the operand signs as presented, with b not inverted.
  assign same_sign = (a_msb == b_msb);
  assign ovf       = (is_sub ? !same_sign : same_sign) && (result[WIDTH-1] != a_msb);
  assign arith     = {result[WIDTH-1], (result[WIDTH-1:0] == '0), result[WIDTH], ovf};

  assign full     = (depth == DW'(DEPTH));
  assign empty    = (depth == '0);
  assign depth_m1 = depth - DW'(1);

  // A simultaneous push and pop cancel each other. Load and ALU updates still apply in that cycle.
  assign push_ok = push && !pop && !full;
  assign pop_ok  = pop && !push && !empty;
  assign err     = (push && pop) || (push && !pop && full) || (pop && !push && empty);

  always_comb begin
    next_flags = flags;
    if (pop_ok) begin
      next_flags = stack[depth_m1[PW-1:0]];
    end else begin
      if (load_en) begin
        next_flags = load_value;
      end else if (alu_valid) begin
        next_flags[3:0] = arith;
      end
      // Entering an interrupt disables interrupts unless a load in this cycle sets them again.
      if (push_ok && !(load_en && load_value[4])) begin
        next_flags[4] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flags     <= '0;
      depth     <= '0;
      stack_err <= 1'b0;
    end else begin
      flags     <= next_flags;
      stack_err <= err;
      if (push_ok) begin
        depth <= depth + DW'(1);
      end else if (pop_ok) begin
        depth <= depth_m1;
      end
    end
  end

  // The stack saves the flags value from before this cycle's update. Stack contents are not reset.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      stack[depth[PW-1:0]] <= flags;
    end
  end

endmodule

// File: tb/tb_flags_unit.sv
module tb_flags_unit;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           alu_valid;
  logic [WIDTH:0] result;
  logic           a_msb;
  logic           b_msb;
  logic           is_sub;
  logic           load_en;
  logic [4:0]     load_value;
  logic           push;
  logic           pop;
  logic [4:0]     flags;
  logic [2:0]     depth;
  logic           stack_err;

  flags_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .alu_valid(alu_valid), .result(result),
    .a_msb(a_msb), .b_msb(b_msb), .is_sub(is_sub), .load_en(load_en),
    .load_value(load_value), .push(push), .pop(pop), .flags(flags),
    .depth(depth), .stack_err(stack_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference state. The shadow stack is modelled as a queue, and overflow comes from true signed arithmetic.
  logic [4:0] mf;
  logic [4:0] mq[$];
  logic       me;
  bit         m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; result = '0; a_msb = 0; b_msb = 0; is_sub = 0;
    load_en = 0; load_value = '0; push = 0; pop = 0; reset = 0;
  endtask

  // Present a real add or subtract of two operands. The subtract carry is the no-borrow carry from a + ~b + 1.
  task automatic set_alu(input logic [15:0] a, input logic [15:0] b, input bit sub);
    int sv;
    alu_valid = 1;
    is_sub = sub;
    a_msb = a[15];
    b_msb = b[15];
    if (sub) begin
      result = {1'b0, a} + {1'b0, ~b} + 17'd1;
      sv = int'($signed(a)) - int'($signed(b));
    end else begin
      result = {1'b0, a} + {1'b0, b};
      sv = int'($signed(a)) + int'($signed(b));
    end
    m_ovf = (sv > 32767) || (sv < -32768);
  endtask

  // Apply one clock with the current inputs, advance the model, and compare all outputs.
  task automatic cyc(input string tag);
    logic [4:0] old;
    logic [3:0] ar;
    #1;
    if (!reset) chk({tag, "/pre_edge_flags"}, flags, mf);
    ar = {result[15], result[15:0] == 16'd0, result[16], m_ovf};
    if (reset) begin
      mf = '0; mq.delete(); me = 0;
    end else begin
      me = (push && pop) || (push && !pop && mq.size() == DEPTH) ||
           (pop && !push && mq.size() == 0);
      old = mf;
      if (pop && !push && mq.size() > 0) begin
        mf = mq.pop_back();
      end else begin
        if (load_en) mf = load_value;
        else if (alu_valid) mf[3:0] = ar;
        if (push && !pop && mq.size() < DEPTH) begin
          mq.push_back(old);
          if (!(load_en && load_value[4])) mf[4] = 1'b0;
        end
      end
    end
    @(posedge clock);
    #1;
    chk({tag, "/flags"}, flags, mf);
    chk({tag, "/depth"}, depth, mq.size());
    chk({tag, "/stack_err"}, stack_err, me);
    idle();
  endtask

  logic [4:0] saved;

  initial begin
    idle();
    m_ovf = 0;
    mf = '0;
    me = 0;

    // Reset dominates a concurrent ALU update and push.
    reset = 1; set_alu(16'h4000, 16'h4000, 0); push = 1; cyc("reset1");
    reset = 1; set_alu(16'h4000, 16'h4000, 0); push = 1; cyc("reset2");
    chk("reset_flags", flags, 5'h00);
    chk("reset_depth", depth, 3'd0);
    chk("reset_err", stack_err, 1'b0);

    // Signed add overflow. The pre-edge check inside cyc confirms there is no combinational path.
    set_alu(16'h4000, 16'h4000, 0); cyc("add_ovf");
    chk("add_ovf_const", flags, 5'h09);

    // A subtract of equal operands sets carry and zero. The update preserves the interrupt-enable bit.
    set_alu(16'h1234, 16'h1234, 1); cyc("sub_eq");
    chk("sub_eq_const", flags, 5'h06);
    load_en = 1; load_value = 5'h10; cyc("load10");
    set_alu(16'h1234, 16'h1234, 1); cyc("sub_eq_ie");
    chk("sub_eq_ie_const", flags, 5'h16);

    // Nested interrupt entry and exit.
    load_en = 1; load_value = 5'h1C; cyc("load1c");
    push = 1; cyc("push1");
    chk("push1_flags", flags, 5'h0C); chk("push1_depth", depth, 3'd1);
    load_en = 1; load_value = 5'h13; cyc("load13");
    push = 1; cyc("push2");
    chk("push2_flags", flags, 5'h03); chk("push2_depth", depth, 3'd2);
    pop = 1; cyc("pop1");
    chk("pop1_flags", flags, 5'h13); chk("pop1_depth", depth, 3'd1);
    pop = 1; cyc("pop2");
    chk("pop2_flags", flags, 5'h1C); chk("pop2_depth", depth, 3'd0);

    // Full-stack and empty-stack boundaries.
    for (int i = 0; i < 5; i++) begin
      push = 1; load_en = 1; load_value = 5'(i + 17); cyc($sformatf("fill%0d", i));
    end
    chk("full_err", stack_err, 1'b1); chk("full_depth", depth, 3'd4);
    cyc("full_idle");
    chk("full_err_pulse", stack_err, 1'b0);
    for (int i = 0; i < 5; i++) begin
      saved = flags;
      pop = 1; cyc($sformatf("drain%0d", i));
    end
    chk("empty_err", stack_err, 1'b1); chk("empty_depth", depth, 3'd0);
    chk("empty_flags_hold", flags, saved);

    // Push and pop in the same cycle cancel each other, but the ALU update still applies.
    push = 1; cyc("pre_simul_push");
    push = 1; pop = 1; set_alu(16'h0000, 16'h0000, 0); cyc("simul");
    chk("simul_err", stack_err, 1'b1); chk("simul_depth", depth, 3'd1);
    chk("simul_flags_lo", flags[3:0], 4'h4);
    saved = mq[0];
    pop = 1; load_en = 1; load_value = 5'h1F; cyc("pop_vs_load");
    chk("pop_wins", flags, saved); chk("pop_wins_depth", depth, 3'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 60) begin
        set_alu(16'($urandom), 16'($urandom), 1'($urandom));
      end else begin
        result = 17'($urandom); a_msb = 1'($urandom); b_msb = 1'($urandom);
      end
      load_en = ($urandom_range(0, 99) < 15);
      load_value = 5'($urandom);
      push = ($urandom_range(0, 99) < 25);
      pop = ($urandom_range(0, 99) < 25);
      reset = ($urandom_range(0, 99) < 2);
      cyc($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
